// File: rtl/genome_unpacker_pkg.sv
// Shared genome codec definitions: base codes, default word geometry and
// the unpacker state encoding.
package genome_unpacker_pkg;

  localparam int BASES_PER_WORD_DEF = 16;

  typedef enum logic [1:0] {
    BASE_A = 2'b00,
    BASE_C = 2'b01,
    BASE_T = 2'b10,
    BASE_G = 2'b11
  } base_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_BUSY  = 1'b1
  } unpack_state_t;

endpackage

// File: rtl/genome_unpacker.sv
// Serialises packed 2-bit base words into one base per cycle with
// valid/ready handshakes on both sides and a running sequence length.
//
// state    | meaning
// ST_EMPTY | remaining-base counter is 0, ready for a new word
// ST_BUSY  | counter > 0, presenting the shift register MSBs
module genome_unpacker
  import genome_unpacker_pkg::*;
#(
  parameter int BASES_PER_WORD = BASES_PER_WORD_DEF,
  parameter int CNT_W          = $clog2(BASES_PER_WORD + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [2*BASES_PER_WORD-1:0] in_data,
  input  logic [CNT_W-1:0]            in_count,
  input  logic                        in_last,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [1:0]                  out_code,
  output logic                        out_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [31:0]                 seq_len
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BASES_PER_WORD);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic [2*BASES_PER_WORD-1:0] sreg;
  logic [CNT_W-1:0]            cnt;
  logic                        last_q;
  logic [CNT_W-1:0]            load_cnt;
  logic                        word_xfer;
  logic                        base_xfer;
  unpack_state_t               state;

  // Zero and out-of-range counts both mean a full word.
  always_comb begin
    load_cnt = in_count;
    if (in_count == '0 || in_count > FULL_CNT) begin
      load_cnt = FULL_CNT;
    end
  end

  always_comb begin
    state = (cnt == '0) ? ST_EMPTY : ST_BUSY;
    out_valid = (state == ST_BUSY);
    in_ready  = (state == ST_EMPTY) || (cnt == ONE_CNT && out_ready);
    out_code  = sreg[2*BASES_PER_WORD-1 -: 2];
    out_last  = last_q && (cnt == ONE_CNT);
    word_xfer = in_valid && in_ready;
    base_xfer = out_valid && out_ready;
  end

  // A load on the final-base edge overrides the shift, giving no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg    <= '0;
      cnt     <= '0;
      last_q  <= 1'b0;
      seq_len <= '0;
    end else begin
      if (word_xfer) begin
        sreg   <= in_data;
        cnt    <= load_cnt;
        last_q <= in_last;
      end else if (base_xfer) begin
        sreg <= sreg << 2;
        cnt  <= cnt - ONE_CNT;
      end
      if (base_xfer) begin
        seq_len <= out_last ? 32'd0 : seq_len + 32'd1;
      end
    end
  end

endmodule

// File: doc/genome_unpacker.md
GENOME_UNPACKER -- requirements
Module: genome_unpacker

Interface
REQ-001 SHALL have parameter BASES_PER_WORD, default 16, giving the number of 2-bit bases per packed input word (legal values 2..16).
REQ-002 SHALL have parameter CNT_W, default 5, giving the width of the count fields; it SHALL equal clog2(BASES_PER_WORD+1).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_data, input, 2*BASES_PER_WORD, packed bases; base 0 occupies the two MSBs.
REQ-006 SHALL have port in_count, input, CNT_W, number of valid bases in in_data, 1..BASES_PER_WORD; value 0 means BASES_PER_WORD.
REQ-007 SHALL have port in_last, input, 1, marks the final word of a sequence.
REQ-008 SHALL have port in_valid, input, 1, upstream word valid.
REQ-009 SHALL have port in_ready, output, 1, unpacker accepts the word this cycle.
REQ-010 SHALL have port out_code, output, 2, one base code (00=A, 01=C, 10=T, 11=G) for the downstream 2-bit-to-ASCII stage.
REQ-011 SHALL have port out_last, output, 1, high with the final base of a word flagged in_last.
REQ-012 SHALL have port out_valid, output, 1, out_code valid.
REQ-013 SHALL have port out_ready, input, 1, downstream accepts out_code this cycle.
REQ-014 SHALL have port seq_len, output, 32, number of bases emitted since the last sequence end; wraps modulo 2^32.

Function
REQ-015 SHALL transfer a word when in_valid and in_ready are both high on a rising edge, and a base when out_valid and out_ready are both high.
REQ-016 SHALL hold a shift register of in_data, a remaining-base counter, and a last flag; states EMPTY (counter 0) and BUSY (counter > 0).
REQ-017 SHALL drive out_valid = 1 exactly in BUSY; out_code = shift register bits [MSB:MSB-1].
REQ-018 SHALL, on each base transfer, shift left by 2 and decrement the counter.
REQ-019 SHALL drive in_ready = 1 when EMPTY, or when counter = 1 and out_ready = 1 (back-to-back load on the same edge as the final base, no bubble).
REQ-020 SHALL load a word with latency 1: first base of an accepted word is presented in the cycle after acceptance.
REQ-021 SHALL sustain one base per cycle across word boundaries when in_valid and out_ready are held high.
REQ-022 SHALL drive out_last = last flag AND counter = 1.
REQ-023 SHALL keep out_code and out_valid stable while out_valid = 1 and out_ready = 0.
REQ-024 SHALL increment seq_len on each base transfer, and set seq_len to 0 on the edge transferring a base with out_last = 1.
REQ-025 SHALL treat in_count > BASES_PER_WORD as BASES_PER_WORD.
REQ-026 SHALL ignore in_data, in_count and in_last whenever in_ready = 0.

Reset
REQ-027 SHALL, while rst_n = 0, asynchronously clear the shift register, counter, last flag and seq_len, giving out_valid = 0, out_code = 00, out_last = 0, in_ready = 1 and seq_len = 0.
REQ-028 SHALL discard any partially emitted word when reset is asserted mid-operation; after release, the first transfer SHALL be a new word.

Structure
REQ-029 SHALL take BASES_PER_WORD defaults and the base-code constants (A=00, C=01, T=10, G=11) from the shared genome package used by the codec stages.
REQ-030 SHALL be a single module with no sub-modules; the counter/shift datapath is one always block plus combinational handshake logic.

Verification
REQ-031 SHALL verify that after reset, word 32'h1B1B_1B1B with count 16, out_ready = 1, produces codes 00,01,10,11 repeated 4 times on 16 consecutive cycles.
REQ-032 SHALL verify that two back-to-back words with in_valid held high give 32 bases with no idle cycle, and in_ready pulses on the 16th base.
REQ-033 SHALL verify that word 32'hE400_0000 with count 3 and last = 1 produces 11,10,01 with out_last on the third base, after which seq_len = 0.
REQ-034 SHALL verify that dropping out_ready for 5 cycles mid-word holds out_code constant and keeps in_ready low, with no base lost or duplicated.
REQ-035 SHALL verify that asserting rst_n = 0 after the 7th base of a 16-base word drops out_valid immediately, sets in_ready = 1 and clears seq_len to 0.
REQ-036 SHALL verify that in_count = 0 yields 16 bases, and in_count = 20 also yields 16 bases.
